// File: rtl/score_pkg.sv
// Shared types and constants for the game-score engine.
package score_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OVER = 2'd2
   } game_state_t;

   // Three packed BCD digits: [11:8] hundreds, [7:4] tens, [3:0] ones
   typedef logic [11:0] bcd3_t;

   localparam bcd3_t BCD_MAX = 12'h999;

endpackage

// File: rtl/bcd3_incr.sv
// Combinational three-digit BCD incrementer; carry_out flags the 999 -> 000 rollover.
module bcd3_incr
   import score_pkg::*;
(
   input  bcd3_t in,
   output bcd3_t out,
   output logic  carry_out
);

   // Ripple the +1 through ones, tens and hundreds, wrapping each 9 to 0
   always_comb begin
      out       = in;
      carry_out = 1'b0;
      if (in[3:0] == 4'd9) begin
         out[3:0] = 4'd0;
         if (in[7:4] == 4'd9) begin
            out[7:4] = 4'd0;
            if (in[11:8] == 4'd9) begin
               out[11:8] = 4'd0;
               carry_out = 1'b1;
            end else begin
               out[11:8] = in[11:8] + 4'd1;
            end
         end else begin
            out[7:4] = in[7:4] + 4'd1;
         end
      end else begin
         out[3:0] = in[3:0] + 4'd1;
      end
   end

endmodule

// File: rtl/score_keeper.sv
// Game-score engine: counts frames from vsync, advances a BCD score while running,
// freezes on collision and keeps a high score. All outputs are registered.
module score_keeper
   import score_pkg::*;
#(
   parameter int FRAMES_PER_POINT = 6,
   parameter bit SATURATE         = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        vga_vs,
   input  logic        start,
   input  logic        collide,
   input  logic        pause,
   output logic [11:0] score_bcd,
   output logic [11:0] hiscore_bcd,
   output logic [1:0]  game_state,
   output logic        score_tick
);

   localparam logic [7:0] DIV_LAST = 8'(FRAMES_PER_POINT - 1);

   game_state_t state, state_next;
   bcd3_t       score, score_next;
   bcd3_t       hiscore, hiscore_next;
   bcd3_t       score_inc;
   logic        score_carry;
   logic [7:0]  div, div_next;
   logic        tick_next;
   logic        vs_d1;
   logic        frame_tick;

   bcd3_incr u_incr (
      .in        (score),
      .out       (score_inc),
      .carry_out (score_carry)
   );

   // One-cycle pulse at the falling edge of the active-low vertical sync
   assign frame_tick = vs_d1 & ~vga_vs;

   // State, score, high score, frame divider and vsync history registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         score      <= '0;
         hiscore    <= '0;
         div        <= '0;
         score_tick <= 1'b0;
         vs_d1      <= 1'b1;
      end else begin
         state      <= state_next;
         score      <= score_next;
         hiscore    <= hiscore_next;
         div        <= div_next;
         score_tick <= tick_next;
         vs_d1      <= vga_vs;
      end
   end

   // Game control: collide beats a same-cycle increment; at 999 the SATURATE policy picks hold or wrap
   always_comb begin
      state_next   = state;
      score_next   = score;
      hiscore_next = hiscore;
      div_next     = div;
      tick_next    = 1'b0;
      unique case (state)
         IDLE, OVER: begin
            if (start) begin
               state_next = RUN;
               score_next = '0;
               div_next   = '0;
            end
         end
         RUN: begin
            if (collide) begin
               state_next = OVER;
               if (score > hiscore) begin
                  hiscore_next = score;
               end
            end else if (frame_tick && !pause) begin
               if (div >= DIV_LAST) begin
                  div_next = '0;
                  if (!(score_carry && SATURATE)) begin
                     score_next = score_inc;
                     tick_next  = 1'b1;
                  end
               end else begin
                  div_next = div + 8'd1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign score_bcd   = score;
   assign hiscore_bcd = hiscore;
   assign game_state  = state;

endmodule
